alu_arbiter: RTL and testbench

- Shares one 16-bit ALU datapath (add, sub, and, or, xor, not) between NREQ requesters.
- Each requester issues an operation with a valid/ready handshake. Requesters are granted round-robin.
- Granted operands are registered and evaluated by the ALU. The result plus C/V/N/Z status is returned, tagged with the requester ID, via a valid/ready response channel.
- Sits between the instruction sequencers and the ALU; the only block allowed to drive ALU operands.

---
 rtl/alu_arbiter.sv | 167 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of one shared 16-bit ALU. One operation is in
// flight at a time: IDLE -> EXEC -> RESP, answered over a valid/ready channel.
module alu_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  input  logic [NREQ*3-1:0]  req_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [15:0]        rsp_result,
  output logic               rsp_c,
  output logic               rsp_v,
  output logic               rsp_n,
  output logic               rsp_z,
  output logic               rsp_err,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;

  state_t            r_state, w_next_state;
  logic [ID_W-1:0]   r_last_grant, r_id, w_grant_idx;
  logic [15:0]       r_a, r_b, w_sel_a, w_sel_b;
  logic [2:0]        r_op, w_sel_op;
  logic              w_found, w_can_accept, w_accept;
  logic [ID_W-1:0]   r_rsp_id;
  logic [15:0]       r_rsp_result;
  logic              r_rsp_c, r_rsp_v, r_rsp_n, r_rsp_z, r_rsp_err;
  logic              w_is_sub, w_c, w_v, w_n, w_z, w_err;
  logic [15:0]       w_b_eff, w_res;
  logic [16:0]       w_sum;

  // Winner is the valid requester with the smallest distance past last_grant.
  always_comb begin
    int rank;
    int best;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_sel_a     = '0;
    w_sel_b     = '0;
    w_sel_op    = '0;
    best        = NREQ;
    rank        = 0;
    for (int i = 0; i < NREQ; i++) begin
      rank = (i + NREQ - 1 - int'(r_last_grant)) % NREQ;
      if (req_valid[i] && rank < best) begin
        best        = rank;
        w_found     = 1'b1;
        w_grant_idx = ID_W'(i);
        w_sel_a     = req_a[16*i +: 16];
        w_sel_b     = req_b[16*i +: 16];
        w_sel_op    = req_op[3*i +: 3];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_RESP;
      S_RESP:  if (rsp_ready) w_next_state = w_accept ? S_EXEC : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_can_accept = !rst && ((r_state == S_IDLE) || (r_state == S_RESP && rsp_ready));
    w_accept     = w_can_accept && w_found;
    rsp_valid    = (r_state == S_RESP);
    busy         = (r_state != S_IDLE);
    req_ready    = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_accept && (w_grant_idx == ID_W'(i));
    end
  end

  // Subtraction runs through the adder as A + ~B + 1; borrow is the inverted carry.
  always_comb begin
    w_is_sub = (r_op == OP_SUB);
    w_b_eff  = w_is_sub ? ~r_b : r_b;
    w_sum    = {1'b0, r_a} + {1'b0, w_b_eff} + {16'd0, w_is_sub};
    w_res    = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    w_n      = 1'b0;
    w_err    = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_res = w_sum[15:0];
        w_c   = w_sum[16] ^ w_is_sub;
        w_v   = (r_a[15] == w_b_eff[15]) && (w_sum[15] != r_a[15]);
        w_n   = w_sum[15];
      end
      OP_AND:  w_res = r_a & r_b;
      OP_OR:   w_res = r_a | r_b;
      OP_XOR:  w_res = r_a ^ r_b;
      OP_NOT:  w_res = ~r_a;
      default: w_err = 1'b1;
    endcase
    w_z = (w_res == 16'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= ID_W'(NREQ - 1);
      r_id         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_c      <= 1'b0;
      r_rsp_v      <= 1'b0;
      r_rsp_n      <= 1'b0;
      r_rsp_z      <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant_idx;
        r_id         <= w_grant_idx;
        r_a          <= w_sel_a;
        r_b          <= w_sel_b;
        r_op         <= w_sel_op;
      end
      if (r_state == S_EXEC) begin
        r_rsp_id     <= r_id;
        r_rsp_result <= w_res;
        r_rsp_c      <= w_c;
        r_rsp_v      <= w_v;
        r_rsp_n      <= w_n;
        r_rsp_z      <= w_z;
        r_rsp_err    <= w_err;
      end
    end
  end

  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_c      = r_rsp_c;
  assign rsp_v      = r_rsp_v;
  assign rsp_n      = r_rsp_n;
  assign rsp_z      = r_rsp_z;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single operations plus
// hand-written sequences for round-robin, back-pressure and mid-flight reset.
module tb_alu_arbiter;
  localparam int NREQ = 2;
  localparam int ID_W = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [NREQ*16-1:0] req_a, req_b;
  logic [NREQ*3-1:0]  req_op;
  logic               rsp_valid, rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [15:0]        rsp_result;
  logic               rsp_c, rsp_v, rsp_n, rsp_z, rsp_err, busy;

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_c(rsp_c), .rsp_v(rsp_v),
    .rsp_n(rsp_n), .rsp_z(rsp_z), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [2:0]  op;
    logic [15:0] a, b, res;
    logic        c, v, n, z, e;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    req_a[16*r +: 16] = a;
    req_b[16*r +: 16] = b;
    req_op[3*r +: 3]  = op;
  endtask

  task automatic check_rsp(input string tag, input int id, input logic [15:0] res,
                           input logic c, input logic v, input logic n, input logic z, input logic e);
    check({tag, ".valid"},  32'(rsp_valid),  32'd1);
    check({tag, ".id"},     32'(rsp_id),     32'(id));
    check({tag, ".result"}, 32'(rsp_result), 32'(res));
    check({tag, ".c"},      32'(rsp_c),      32'(c));
    check({tag, ".v"},      32'(rsp_v),      32'(v));
    check({tag, ".n"},      32'(rsp_n),      32'(n));
    check({tag, ".z"},      32'(rsp_z),      32'(z));
    check({tag, ".err"},    32'(rsp_err),    32'(e));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One isolated operation: grant, one EXEC cycle, then response on the next cycle.
  task automatic apply_vec(input int idx, input vec_t t);
    int    waited;
    string tag;
    waited = 0;
    tag    = $sformatf("vec%0d", idx);
    @(negedge clk);
    set_req(t.r, t.op, t.a, t.b);
    req_valid      = '0;
    req_valid[t.r] = 1'b1;
    rsp_ready      = 1'b1;
    #1;
    while (!req_ready[t.r] && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check({tag, ".grant"}, 32'(req_ready[t.r]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    #1;
    check({tag, ".exec_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".exec_busy"},  32'(busy),      32'd1);
    @(negedge clk);
    #1;
    check_rsp(tag, t.r, t.res, t.c, t.v, t.n, t.z, t.e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1, 3'b001, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{0, 3'b001, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1, 3'b100, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{0, 3'b111, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1, 3'b101, 16'h00FF, 16'h1111, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{0, 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1, 3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{0, 3'b011, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1, 3'b001, 16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{0, 3'b110, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;

    // Reset state, with requests pending to prove req_ready stays low.
    @(negedge clk);
    @(negedge clk);
    req_valid = '1;
    #1;
    check("reset.req_ready",  32'(req_ready),  32'd0);
    check("reset.rsp_valid",  32'(rsp_valid),  32'd0);
    check("reset.busy",       32'(busy),       32'd0);
    check("reset.rsp_result", 32'(rsp_result), 32'd0);
    check("reset.rsp_id",     32'(rsp_id),     32'd0);
    check("reset.flags", 32'({rsp_c, rsp_v, rsp_n, rsp_z, rsp_err}), 32'd0);
    req_valid = '0;
    rst       = 1'b0;

    for (int i = 0; i < 11; i++) apply_vec(i, vecs[i]);

    // Round robin with both requesters permanently valid.
    do_reset();
    set_req(0, 3'b000, 16'h0001, 16'h0001);
    set_req(1, 3'b000, 16'h0010, 16'h0020);
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    check("rr.first_ready", 32'(req_ready), 32'b01);
    for (int g = 0; g < 4; g++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      check($sformatf("rr%0d.exec_valid", g), 32'(rsp_valid), 32'd0);
      check($sformatf("rr%0d.exec_ready", g), 32'(req_ready), 32'd0);
      @(negedge clk);
      #1;
      check($sformatf("rr%0d.valid", g),  32'(rsp_valid), 32'd1);
      check($sformatf("rr%0d.id", g),     32'(rsp_id),    32'(g % 2));
      check($sformatf("rr%0d.result", g), 32'(rsp_result), (g % 2 == 0) ? 32'h0002 : 32'h0030);
      check($sformatf("rr%0d.ready", g),  32'(req_ready), (g % 2 == 0) ? 32'b10 : 32'b01);
    end
    @(negedge clk);
    req_valid = '0;

    // Back-pressure: response held five cycles, then same-cycle accept on release.
    do_reset();
    set_req(0, 3'b001, 16'h0010, 16'h0001);
    set_req(1, 3'b011, 16'h0A00, 16'h00B0);
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    check("bp.first_ready", 32'(req_ready), 32'b01);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("bp.exec_valid", 32'(rsp_valid), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("bp%0d.valid", k),  32'(rsp_valid),  32'd1);
      check($sformatf("bp%0d.id", k),     32'(rsp_id),     32'd0);
      check($sformatf("bp%0d.result", k), 32'(rsp_result), 32'h000F);
      check($sformatf("bp%0d.ready", k),  32'(req_ready),  32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(req_ready), 32'b10);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("bp.second_exec_valid", 32'(rsp_valid), 32'd0);
    check("bp.second_exec_busy",  32'(busy),      32'd1);
    @(negedge clk);
    req_valid = '0;
    #1;
    check_rsp("bp.second", 1, 16'h0AB0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while an operation sits in EXEC: it is dropped and the pointer restarts.
    do_reset();
    set_req(0, 3'b000, 16'h0005, 16'h0006);
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 2'b01;
    #1;
    check("rx.grant", 32'(req_ready), 32'b01);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("rx.exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rx.reset_valid", 32'(rsp_valid), 32'd0);
    check("rx.reset_busy",  32'(busy),      32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rx.after_valid", 32'(rsp_valid), 32'd0);
    check("rx.after_busy",  32'(busy),      32'd0);
    req_valid = 2'b11;
    #1;
    check("rx.next_grant", 32'(req_ready), 32'b01);
    @(negedge clk);
    req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
